// File: rtl/duration_counter_multi.sv
// Multi-channel tick-driven down-counters with restartable load, per-channel halt and readable count.
// Optional DURATION_COUNTER_LOOP_EN adds i_loop: a terminal tick reloads instead of stopping.

module duration_counter_lane #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] duration,
    input  logic             loop,
    output logic             done,
    output logic             active,
    output logic [WIDTH-1:0] count
);
    typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

    state_t           state;
    logic [WIDTH-1:0] reload;

    // Done is combinational so the sequencer sees it in the terminal tick cycle itself.
    assign done   = (state == RUNNING) & tick & (count == '0);
    assign active = (state == RUNNING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= STOPPED;
            count  <= '0;
            reload <= '0;
        end else begin
            case (state)
                STOPPED: begin
                    if (load) begin
                        count  <= duration;
                        reload <= duration;
                        state  <= RUNNING;
                    end
                end
                RUNNING: begin
                    if (load) begin
                        count  <= duration;
                        reload <= duration;
                    end else if (tick) begin
                        if (count != '0) count <= count - WIDTH'(1);
                        else if (loop)   count <= reload;
                        else             state <= STOPPED;
                    end
                end
                default: state <= STOPPED;
            endcase
        end
    end
endmodule

module duration_counter_multi #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic [CHANNELS-1:0]       i_load,
    input  logic [CHANNELS*WIDTH-1:0] i_duration,
    input  logic [CHANNELS-1:0]       i_halt,
`ifdef DURATION_COUNTER_LOOP_EN
    input  logic [CHANNELS-1:0]       i_loop,
`endif
    output logic [CHANNELS-1:0]       o_done,
    output logic [CHANNELS-1:0]       o_active,
    output logic [CHANNELS*WIDTH-1:0] o_count
);
    logic [CHANNELS-1:0] loop;

`ifdef DURATION_COUNTER_LOOP_EN
    assign loop = i_loop;
`else
    assign loop = '0;
`endif

    for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
        duration_counter_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (i_clk),
            .rst_n    (i_rst_n),
            .tick     (i_enable & ~i_halt[n]),
            .load     (i_load[n]),
            .duration (i_duration[n*WIDTH +: WIDTH]),
            .loop     (loop[n]),
            .done     (o_done[n]),
            .active   (o_active[n]),
            .count    (o_count[n*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_duration_counter_multi.sv
// Bench for duration_counter_multi: per-cycle model comparison plus directed literal checks.
// Loop scenario is exercised only when DURATION_COUNTER_LOOP_EN is defined.

module tb_duration_counter_multi;
    localparam int WIDTH = 5;
    localparam int CH    = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic [CH-1:0]       load;
    logic [CH*WIDTH-1:0] dur;
    logic [CH-1:0]       halt;
    logic [CH-1:0]       loop;
    logic [CH-1:0]       done;
    logic [CH-1:0]       active;
    logic [CH*WIDTH-1:0] count;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    duration_counter_multi #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (en),
        .i_load     (load),
        .i_duration (dur),
        .i_halt     (halt),
`ifdef DURATION_COUNTER_LOOP_EN
        .i_loop     (loop),
`endif
        .o_done     (done),
        .o_active   (active),
        .o_count    (count)
    );

    // Model: per channel, "remaining ticks before the terminal one" and a running flag.
    int m_left [CH];
    int m_dur  [CH];
    bit m_run  [CH];

    function automatic bit loop_on(int n);
`ifdef DURATION_COUNTER_LOOP_EN
        return loop[n];
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_done(int n);
        return m_run[n] && en && !halt[n] && m_left[n] == 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int n = 0; n < CH; n++) begin
            if (!rst_n) begin
                m_left[n] = 0; m_dur[n] = 0; m_run[n] = 0;
            end else if (load[n]) begin
                m_dur[n]  = int'(dur[n*WIDTH +: WIDTH]);
                m_left[n] = m_dur[n];
                m_run[n]  = 1;
            end else if (m_run[n] && en && !halt[n]) begin
                if (m_left[n] > 0)   m_left[n] = m_left[n] - 1;
                else if (loop_on(n)) m_left[n] = m_dur[n];
                else                 m_run[n]  = 0;
            end
        end
    end

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int n = 0; n < CH; n++) begin
            chk($sformatf("model done[%0d]", n), int'(done[n]), int'(m_done(n)));
            chk($sformatf("model active[%0d]", n), int'(active[n]), int'(m_run[n]));
            chk($sformatf("model count[%0d]", n), int'(count[n*WIDTH +: WIDTH]), m_left[n]);
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_load(int n, int d);
        load[n] = 1'b1;
        dur[n*WIDTH +: WIDTH] = WIDTH'(d);
    endtask

    // One tick with the done bit captured mid-cycle, then one idle clock.
    task automatic tick(output logic [CH-1:0] d);
        en = 1'b1; #3; d = done; cyc(); en = 1'b0; load = '0; cyc();
    endtask

    function automatic int cnt(int n);
        return int'(count[n*WIDTH +: WIDTH]);
    endfunction

    logic [CH-1:0] d;

    initial begin
        rst_n = 1'b0; en = 1'b0; load = '0; dur = '0; halt = '0; loop = '0;
        cyc(); cyc();
        chk("reset active", int'(active), 0);
        chk("reset count", int'(count), 0);
        chk("reset done", int'(done), 0);
        rst_n = 1'b1; cyc();

        // basic: D=3, four ticks
        do_load(0, 3); cyc(); load = '0;
        chk("basic count0 after load", cnt(0), 3);
        chk("basic active0 after load", int'(active[0]), 1);
        for (int k = 0; k < 4; k++) begin
            tick(d);
            chk($sformatf("basic done0 tick%0d", k + 1), int'(d[0]), (k == 3) ? 1 : 0);
            chk($sformatf("basic count0 tick%0d", k + 1), cnt(0), (k < 3) ? 2 - k : 0);
            chk($sformatf("basic active0 tick%0d", k + 1), int'(active[0]), (k < 3) ? 1 : 0);
        end

        // zero duration
        do_load(0, 0); cyc(); load = '0;
        tick(d);
        chk("zero done0 tick1", int'(d[0]), 1);
        chk("zero active0 after", int'(active[0]), 0);

        // max duration
        do_load(1, 31); cyc(); load = '0;
        for (int k = 1; k <= 32; k++) begin
            tick(d);
            if (k == 31) chk("max done1 tick31", int'(d[1]), 0);
            if (k == 32) chk("max done1 tick32", int'(d[1]), 1);
        end
        chk("max active1 after", int'(active[1]), 0);

        // halt
        do_load(1, 2); cyc(); load = '0;
        halt[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(d);
            chk("halt done1", int'(d[1]), 0);
        end
        chk("halt count1 frozen", cnt(1), 2);
        chk("halt active1 held", int'(active[1]), 1);
        halt[1] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick(d);
            chk($sformatf("halt release done1 tick%0d", k), int'(d[1]), (k == 3) ? 1 : 0);
        end

        // restart on terminal, ch3 concurrent
        do_load(2, 1); do_load(3, 7); cyc(); load = '0;
        tick(d);
        en = 1'b1; do_load(2, 5); #3;
        chk("collide done2", int'(done[2]), 1);
        chk("collide done3", int'(done[3]), 0);
        cyc(); en = 1'b0; load = '0;
        chk("collide count2", cnt(2), 5);
        chk("collide active2", int'(active[2]), 1);
        chk("collide count3", cnt(3), 5);
        chk("collide active3", int'(active[3]), 1);
        cyc();

`ifdef DURATION_COUNTER_LOOP_EN
        load = '0; cyc();
        loop[0] = 1'b1;
        do_load(0, 1); cyc(); load = '0;
        for (int k = 1; k <= 6; k++) begin
            tick(d);
            chk($sformatf("loop done0 tick%0d", k), int'(d[0]), (k % 2 == 0) ? 1 : 0);
            chk($sformatf("loop active0 tick%0d", k), int'(active[0]), 1);
        end
        loop[0] = 1'b0;
        tick(d); tick(d);
        chk("loop clear done0", int'(d[0]), 1);
        chk("loop clear active0", int'(active[0]), 0);
`endif

        // asynchronous reset mid-count, with a tick pending
        do_load(0, 10); cyc(); load = '0;
        tick(d); tick(d);
        en = 1'b1; #2; rst_n = 1'b0; #1;
        chk("async reset active", int'(active), 0);
        chk("async reset count", int'(count), 0);
        chk("async reset done", int'(done), 0);
        cyc(); en = 1'b0; cyc();
        rst_n = 1'b1; cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
